// File: rtl/retire_trace_buffer_if.sv
// Retirement-record and trace-drain signals of the retire trace buffer.
// The master drives records and consumer ready; the slave is the buffer.
interface retire_trace_buffer_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8,
  parameter int SEQ_W = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             update_i;
  logic [XLEN-1:0]  pc_i;
  logic [XLEN-1:0]  instr_i;
  logic [4:0]       reg_addr_i;
  logic [XLEN-1:0]  reg_data_i;
  logic             flush_i;
  logic             trace_valid_o;
  logic             trace_ready_i;
  logic [XLEN-1:0]  trace_pc_o;
  logic [XLEN-1:0]  trace_instr_o;
  logic [4:0]       trace_rd_o;
  logic [XLEN-1:0]  trace_data_o;
  logic [SEQ_W-1:0] trace_seq_o;
  logic [CW-1:0]    count_o;
  logic             full_o;
  logic             empty_o;
  logic [SEQ_W-1:0] drop_cnt_o;

  modport master (
    output update_i, pc_i, instr_i, reg_addr_i,
    output reg_data_i, flush_i, trace_ready_i,
    input  trace_valid_o, trace_pc_o, trace_instr_o,
    input  trace_rd_o, trace_data_o, trace_seq_o,
    input  count_o, full_o, empty_o, drop_cnt_o
  );

  modport slave (
    input  update_i, pc_i, instr_i, reg_addr_i,
    input  reg_data_i, flush_i, trace_ready_i,
    output trace_valid_o, trace_pc_o, trace_instr_o,
    output trace_rd_o, trace_data_o, trace_seq_o,
    output count_o, full_o, empty_o, drop_cnt_o
  );
endinterface

// File: rtl/retire_trace_buffer.sv
// Sequence-tagged FIFO between core retirement and a trace consumer.
// Overflowing records are dropped and counted with a saturating counter.
module retire_trace_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8,
  parameter int SEQ_W = 32
) (
  input logic clk_i,
  input logic rst_i,
  retire_trace_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  instr;
    logic [4:0]       rd;
    logic [XLEN-1:0]  data;
  } rec_t;

  rec_t             mem_q [DEPTH];
  rec_t             wr_rec;
  rec_t             head;
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic [SEQ_W-1:0] seq_q;
  logic [SEQ_W-1:0] drop_q;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push;
  logic             drop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  // Flush overrides both sides of the handshake for that cycle
  assign pop  = !empty && bus.trace_ready_i && !bus.flush_i;
  assign push = bus.update_i && !bus.flush_i && (!full || pop);
  assign drop = bus.update_i && !bus.flush_i && full && !pop;

  assign wr_rec = '{
    seq:   seq_q,
    pc:    bus.pc_i,
    instr: bus.instr_i,
    rd:    bus.reg_addr_i,
    data:  bus.reg_data_i
  };

  assign head = mem_q[rd_q];

  assign bus.trace_valid_o = !empty;
  assign bus.trace_pc_o    = head.pc;
  assign bus.trace_instr_o = head.instr;
  assign bus.trace_rd_o    = head.rd;
  assign bus.trace_data_o  = head.data;
  assign bus.trace_seq_o   = head.seq;
  assign bus.count_o       = cnt_q;
  assign bus.full_o        = full;
  assign bus.empty_o       = empty;
  assign bus.drop_cnt_o    = drop_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_q] <= wr_rec;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (bus.flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      if (push && !pop)
        cnt_q <= cnt_q + CW'(1);
      else if (pop && !push)
        cnt_q <= cnt_q - CW'(1);
    end
  end

  // Sequence numbers advance on every strobe, even dropped or flushed ones
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      seq_q  <= '0;
      drop_q <= '0;
    end else begin
      if (bus.update_i) seq_q <= seq_q + SEQ_W'(1);
      if (drop && (drop_q != '1))
        drop_q <= drop_q + SEQ_W'(1);
    end
  end
endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer: reset, single record,
// fill/drop, full push+pop, flush and async reset.
module tb_retire_trace_buffer;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  retire_trace_buffer_if #(.XLEN(32), .DEPTH(8), .SEQ_W(32)) bus ();

  retire_trace_buffer #(.XLEN(32), .DEPTH(8), .SEQ_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.update_i      = 1'b0;
    bus.pc_i          = '0;
    bus.instr_i       = '0;
    bus.reg_addr_i    = '0;
    bus.reg_data_i    = '0;
    bus.flush_i       = 1'b0;
    bus.trace_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic rec(input logic [31:0] pc, input logic [31:0] ins,
                     input logic [4:0] rd, input logic [31:0] dat);
    bus.update_i   = 1'b1;
    bus.pc_i       = pc;
    bus.instr_i    = ins;
    bus.reg_addr_i = rd;
    bus.reg_data_i = dat;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle_inputs();
    #2;
    chk("rst_valid", 64'(bus.trace_valid_o), 64'd0);
    chk("rst_count", 64'(bus.count_o), 64'd0);
    chk("rst_empty", 64'(bus.empty_o), 64'd1);
    chk("rst_full", 64'(bus.full_o), 64'd0);
    chk("rst_pc", 64'(bus.trace_pc_o), 64'd0);
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("idle_valid", 64'(bus.trace_valid_o), 64'd0);
    chk("idle_count", 64'(bus.count_o), 64'd0);
    chk("idle_drop", 64'(bus.drop_cnt_o), 64'd0);
    chk("idle_empty", 64'(bus.empty_o), 64'd1);

    // single record, ready held high
    bus.trace_ready_i = 1'b1;
    rec(32'h100, 32'h0050_0093, 5'd1, 32'd5);
    step();
    bus.update_i = 1'b0;
    chk("one_valid", 64'(bus.trace_valid_o), 64'd1);
    chk("one_pc", 64'(bus.trace_pc_o), 64'h100);
    chk("one_instr", 64'(bus.trace_instr_o), 64'h0050_0093);
    chk("one_rd", 64'(bus.trace_rd_o), 64'd1);
    chk("one_data", 64'(bus.trace_data_o), 64'd5);
    chk("one_seq", 64'(bus.trace_seq_o), 64'd0);
    step();
    chk("one_empty", 64'(bus.empty_o), 64'd1);
    chk("one_valid0", 64'(bus.trace_valid_o), 64'd0);

    // fill and drop from a clean start
    idle_inputs();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      rec(32'h200 + 32'(4 * i), 32'h13, 5'(i), 32'(i));
      step();
    end
    bus.update_i = 1'b0;
    chk("fill_count", 64'(bus.count_o), 64'd8);
    chk("fill_full", 64'(bus.full_o), 64'd1);
    chk("fill_drop", 64'(bus.drop_cnt_o), 64'd2);
    chk("fill_seq", 64'(bus.trace_seq_o), 64'd0);

    // full with simultaneous push and pop
    rec(32'h300, 32'h33, 5'd9, 32'hABCD);
    bus.trace_ready_i = 1'b1;
    step();
    bus.update_i = 1'b0;
    bus.trace_ready_i = 1'b0;
    chk("pp_count", 64'(bus.count_o), 64'd8);
    chk("pp_drop", 64'(bus.drop_cnt_o), 64'd2);
    chk("pp_head_seq", 64'(bus.trace_seq_o), 64'd1);
    chk("pp_head_pc", 64'(bus.trace_pc_o), 64'h204);

    // head stays stable while not ready
    step();
    chk("hold_seq", 64'(bus.trace_seq_o), 64'd1);

    bus.trace_ready_i = 1'b1;
    for (int i = 1; i < 8; i++) begin
      chk("drain_valid", 64'(bus.trace_valid_o), 64'd1);
      chk("drain_seq", 64'(bus.trace_seq_o), 64'(i));
      chk("drain_pc", 64'(bus.trace_pc_o), 64'(32'h200 + 32'(4 * i)));
      step();
    end
    chk("tail_seq", 64'(bus.trace_seq_o), 64'd10);
    chk("tail_pc", 64'(bus.trace_pc_o), 64'h300);
    chk("tail_data", 64'(bus.trace_data_o), 64'hABCD);
    step();
    chk("drain_empty", 64'(bus.empty_o), 64'd1);
    chk("drain_drop", 64'(bus.drop_cnt_o), 64'd2);

    // flush with coincident update
    idle_inputs();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rec(32'h400 + 32'(4 * i), 32'h13, 5'd2, 32'(i));
      step();
    end
    bus.update_i = 1'b0;
    chk("pre_flush_count", 64'(bus.count_o), 64'd4);
    rec(32'h4F0, 32'h13, 5'd3, 32'd77);
    bus.flush_i = 1'b1;
    bus.trace_ready_i = 1'b1;
    step();
    bus.update_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.trace_ready_i = 1'b0;
    chk("flush_count", 64'(bus.count_o), 64'd0);
    chk("flush_valid", 64'(bus.trace_valid_o), 64'd0);
    chk("flush_drop", 64'(bus.drop_cnt_o), 64'd0);
    rec(32'h500, 32'h13, 5'd4, 32'd9);
    step();
    bus.update_i = 1'b0;
    chk("post_flush_seq", 64'(bus.trace_seq_o), 64'd5);
    chk("post_flush_pc", 64'(bus.trace_pc_o), 64'h500);
    chk("post_flush_count", 64'(bus.count_o), 64'd1);

    // async reset between edges
    bus.trace_ready_i = 1'b1;
    step();
    bus.trace_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rec(32'h600 + 32'(4 * i), 32'h13, 5'd5, 32'(i));
      step();
    end
    bus.update_i = 1'b0;
    chk("pre_rst_count", 64'(bus.count_o), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.trace_valid_o), 64'd0);
    chk("arst_count", 64'(bus.count_o), 64'd0);
    chk("arst_pc", 64'(bus.trace_pc_o), 64'd0);
    step();
    rst = 1'b0;
    rec(32'h700, 32'h13, 5'd6, 32'd1);
    step();
    bus.update_i = 1'b0;
    chk("arst_seq", 64'(bus.trace_seq_o), 64'd0);
    chk("arst_new_pc", 64'(bus.trace_pc_o), 64'h700);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/retire_trace_buffer.md
# retire_trace_buffer

Buffers instruction-retirement records from the multicycle core and drains them to a trace/checker port over a valid/ready handshake. It sits directly downstream of the core's retirement outputs (update, pc, instr, rd, write-back data). It decouples the core, which retires at most one record per cycle, from a slower or stalling trace consumer. Each record is tagged with a sequence number, and records that cannot be buffered are counted, never silently lost.

## Interface
- XLEN, 32, datapath width of PC, instruction and write-back data
- DEPTH, 8, FIFO entries; must be a power of two, at least 2
- SEQ_W, 32, width of sequence-number and drop counters
- clk_i  in  1  system clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- update_i  in  1  retirement strobe from core; one record per cycle when high
- pc_i  in  XLEN  retired PC
- instr_i  in  XLEN  retired instruction
- reg_addr_i  in  5  retired rd
- reg_data_i  in  XLEN  value written to rd
- flush_i  in  1  synchronous FIFO clear
- trace_valid_o  out  1  head record available
- trace_ready_i  in  1  consumer accepts head record
- trace_pc_o / trace_instr_o  out  XLEN each  head record PC / instruction
- trace_rd_o  out  5  head record rd
- trace_data_o  out  XLEN  head record write-back data
- trace_seq_o  out  SEQ_W  head record sequence number
- count_o  out  $clog2(DEPTH)+1  current occupancy
- full_o / empty_o  out  1 each  occupancy == DEPTH / occupancy == 0
- drop_cnt_o  out  SEQ_W  records dropped; saturates at all-ones

## Operation
- Storage is a DEPTH-entry register array holding {seq, pc, instr, rd, data}, with write pointer, read pointer and count, each log2(DEPTH) bits plus count MSB.
- Pointers wrap modulo DEPTH.
- Sequence counter seq_q increments on every cycle with update_i=1, whether the record is accepted, dropped or flushed. It wraps modulo 2^SEQ_W. The record stores the pre-increment value, so the first record after reset has seq 0.
- Pop happens when trace_valid_o && trace_ready_i. The read pointer advances.
- Push happens when update_i && !flush_i && (!full_o || pop). The entry is written at the write pointer and the write pointer advances.
  - Push and pop in the same cycle with the FIFO full are legal. Count is unchanged.
- Drop happens when update_i && !flush_i && full_o && !pop.
  - The record is discarded and drop_cnt increments, saturating.
  - The FIFO is unchanged.
- Flush: flush_i=1 zeroes the pointers and count at the edge. Pop and push in that cycle are ignored. seq_q and drop_cnt are not cleared. An update_i coincident with flush is discarded and not counted as a drop.
- Count update: count += push − pop.
- Outputs are combinational from state only. trace_valid_o = !empty_o. Head fields are read from the array at the read pointer. When empty, head fields hold the stale entry contents, and the consumer must ignore them.
- trace_* outputs must not depend combinationally on update_i or trace_ready_i.

## Timing
- Reset (async assert): pointers, count, seq_q and drop_cnt are 0. trace_valid_o=0, empty_o=1, full_o=0, count_o=0. The storage array is also cleared to 0, so all trace_* data outputs read 0.
- Reset deassertion is synchronous to clk_i by the system. Behaviour is normal from the first edge after release.
- Latency: a record presented with update_i at edge N appears at the head at N+1 if the FIFO was empty. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle. A consumer holding ready high sustains full core rate with no drops.
- Handshake: the head record and trace_valid_o stay stable until popped or flushed. A consumer may raise ready independently of valid.
- Asserting reset mid-stream discards all buffered records immediately, without waiting for a clock edge.

## Test plan
- Reset then idle: rst_i pulse, 3 cycles idle -> trace_valid_o=0, count_o=0, drop_cnt_o=0, empty_o=1.
- Single record: update_i with pc=0x100, instr=0x00500093, rd=1, data=5, ready=1 -> next cycle valid=1 with those fields and seq=0. Popped on that edge; empty afterwards.
- Fill and drop (DEPTH=8): ready=0, 10 consecutive updates -> count_o=8, full_o=1, drop_cnt_o=2. Draining with ready=1 yields seq 0..7 in order, with no seq 8 or 9 emitted.
- Full with simultaneous push/pop: FIFO full, update_i=1 and ready=1 in the same cycle -> count stays 8, drop_cnt unchanged, and the new record is at the tail with the next seq.
- Flush: 4 records buffered, flush_i=1 with update_i=1 -> next cycle count_o=0, valid=0, drop_cnt unchanged. The next accepted record carries seq 5.
- Async reset mid-operation: 3 records buffered, rst_i asserted between edges -> valid drops to 0 and count_o to 0 before the next edge. After release, the first record has seq 0.
